// File: rtl/r3_triplet_gather.sv
// r3_triplet_gather: radix-3 FFT input stage. Collects three consecutive
// serial complex samples into one parallel triplet (x0 oldest, x2 newest),
// with valid/ready on both sides and frame-position tracking (out_idx,
// out_last). The optional per-sample 1/2 prescale is enabled by defining
// the macro R3_PRESCALE_EN.
module r3_triplet_gather #(
  parameter int DW = 32,
  parameter int N  = 27,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  localparam int HW = DW / 2;
  localparam int NT = N / 3;
  localparam logic [IW-1:0] TLAST = IW'(NT - 1);

`ifdef R3_PRESCALE_EN
  // (v + 1) >>> 1 in one extra bit: round half up, result always fits HW bits
  function automatic logic [HW-1:0] half_round(input logic signed [HW-1:0] v);
    logic signed [HW:0] w;
    w = $signed({v[HW-1], v}) + $signed((HW+1)'(1));
    w = w >>> 1;
    return w[HW-1:0];
  endfunction

  function automatic logic [DW-1:0] prescale(input logic [DW-1:0] d);
    return {half_round(d[DW-1:HW]), half_round(d[HW-1:0])};
  endfunction
`else
  function automatic logic [DW-1:0] prescale(input logic [DW-1:0] d);
    return d;
  endfunction
`endif

  logic [1:0]    slot_q, slot_d;
  logic [IW-1:0] tidx_q, tidx_d;
  logic [DW-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [DW-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] samp;
  logic          accept;
  logic          drain;

  // Only the slot-2 sample needs room in the output register; flush always
  // accepts (and discards) so the upstream is never blocked while clearing.
  assign in_ready = flush || !(slot_q == 2'd2 && vld_q && !out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = vld_q && out_ready;
  assign samp     = prescale(in_data);

  // Next-state: slot sequencing, partial-triplet capture, output register load
  always_comb begin
    slot_d = slot_q;
    tidx_d = tidx_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    x0_d   = x0_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    idx_d  = idx_q;
    last_d = last_q;
    vld_d  = vld_q;
    if (flush) begin
      slot_d = 2'd0;
      tidx_d = '0;
      vld_d  = 1'b0;
    end else begin
      if (drain) vld_d = 1'b0;
      if (accept) begin
        case (slot_q)
          2'd0: begin
            s0_d   = samp;
            slot_d = 2'd1;
          end
          2'd1: begin
            s1_d   = samp;
            slot_d = 2'd2;
          end
          default: begin
            // Loading here overrides a same-cycle drain: no bubble
            x0_d   = s0_q;
            x1_d   = s1_q;
            x2_d   = samp;
            idx_d  = tidx_q;
            last_d = (tidx_q == TLAST);
            vld_d  = 1'b1;
            tidx_d = (tidx_q == TLAST) ? '0 : tidx_q + IW'(1);
            slot_d = 2'd0;
          end
        endcase
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 2'd0;
      tidx_q <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      tidx_q <= tidx_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      vld_q  <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign x0        = x0_q;
  assign x1        = x1_q;
  assign x2        = x2_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_r3_triplet_gather.sv
// Directed testbench for r3_triplet_gather with N=9 (three triplets/frame).
module tb_r3_triplet_gather;

  localparam int DW = 32;
  localparam int N  = 9;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] x0, x1, x2;
  logic [IW-1:0] out_idx;
  logic          out_last;

  int vecs = 0;
  int errs = 0;

  r3_triplet_gather #(.DW(DW), .N(N), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0(x0), .x1(x1), .x2(x2), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Input sample k: both halves equal to k
  function automatic logic [31:0] val(input int k);
    logic [15:0] h;
    h = k[15:0];
    return {h, h};
  endfunction

  // Expected stored value of sample k (halved, rounded up, when prescaled)
  function automatic logic [31:0] ev(input int k);
    logic [15:0] h;
`ifdef R3_PRESCALE_EN
    h = 16'((k + 1) >>> 1);
`else
    h = k[15:0];
`endif
    return {h, h};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k);
    in_valid = 1'b1;
    in_data  = val(k);
    tick();
  endtask

  task automatic test_reset;
    #12;
    vecs++;
    if ({out_valid, x0, x1, x2, out_idx, out_last, in_ready} !== {1'b0, 96'd0, 8'd0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL reset_state: got v=%0b x0=%h x1=%h x2=%h idx=%0d last=%0b rdy=%0b, want all 0 and rdy=1",
               out_valid, x0, x1, x2, out_idx, out_last, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      in_valid = 1'b1;
      in_data  = val(k);
      #1;
      vecs++;
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL stream_ready k=%0d: got %0b, want 1", k, in_ready);
      end
      tick();
      if (k % 3 == 0) begin
        vecs++;
        if ({out_valid, x0, x1, x2, out_idx, out_last} !==
            {1'b1, ev(k-2), ev(k-1), ev(k), 8'(k/3 - 1), (k == 9)}) begin
          errs++;
          $display("FAIL stream_triplet k=%0d: got v=%0b %h %h %h idx=%0d last=%0b, want 1 %h %h %h idx=%0d last=%0b",
                   k, out_valid, x0, x1, x2, out_idx, out_last, ev(k-2), ev(k-1), ev(k), k/3 - 1, k == 9);
        end
      end else if (k % 3 == 1 && k > 1) begin
        vecs++;
        if (out_valid !== 1'b0) begin
          errs++;
          $display("FAIL stream_drain k=%0d: got out_valid=%0b, want 0", k, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    send(1); send(2); send(3);
    out_ready = 1'b0;
    send(4); send(5);
    in_valid = 1'b1;
    in_data  = val(6);
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_stall i=%0d: got in_ready=%0b, want 0", i, in_ready);
      end
      tick();
      vecs++;
      if ({out_valid, x0, x1, x2, out_idx} !== {1'b1, ev(1), ev(2), ev(3), 8'd0}) begin
        errs++;
        $display("FAIL bp_hold i=%0d: got v=%0b %h %h %h idx=%0d, want 1 %h %h %h idx=0",
                 i, out_valid, x0, x1, x2, out_idx, ev(1), ev(2), ev(3));
      end
    end
    out_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_release_ready: got %0b, want 1", in_ready);
    end
    tick();
    vecs++;
    if ({out_valid, x0, x1, x2, out_idx, out_last} !== {1'b1, ev(4), ev(5), ev(6), 8'd1, 1'b0}) begin
      errs++;
      $display("FAIL bp_reload: got v=%0b %h %h %h idx=%0d last=%0b, want 1 %h %h %h idx=1 last=0",
               out_valid, x0, x1, x2, out_idx, out_last, ev(4), ev(5), ev(6));
    end
    in_valid = 1'b0;
    tick();
    vecs++;
    if ({out_valid, x0} !== {1'b0, ev(4)}) begin
      errs++;
      $display("FAIL bp_drain_hold: got v=%0b x0=%h, want 0 %h", out_valid, x0, ev(4));
    end
  endtask

  task automatic test_gap;
    out_ready = 1'b1;
    send(7); send(8);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL gap_idle i=%0d: got out_valid=%0b, want 0", i, out_valid);
      end
    end
    send(9);
    vecs++;
    if ({out_valid, x0, x1, x2, out_idx, out_last} !== {1'b1, ev(7), ev(8), ev(9), 8'd2, 1'b1}) begin
      errs++;
      $display("FAIL gap_triplet: got v=%0b %h %h %h idx=%0d last=%0b, want 1 %h %h %h idx=2 last=1",
               out_valid, x0, x1, x2, out_idx, out_last, ev(7), ev(8), ev(9));
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    send(30); send(31); send(32);
    out_ready = 1'b0;
    send(20); send(21);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = val(99);
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_ready: got %0b, want 1", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_valid: got out_valid=%0b, want 0", out_valid);
    end
    out_ready = 1'b1;
    send(10); send(11); send(12);
    vecs++;
    if ({out_valid, x0, x1, x2, out_idx, out_last} !== {1'b1, ev(10), ev(11), ev(12), 8'd0, 1'b0}) begin
      errs++;
      $display("FAIL flush_triplet: got v=%0b %h %h %h idx=%0d last=%0b, want 1 %h %h %h idx=0 last=0",
               out_valid, x0, x1, x2, out_idx, out_last, ev(10), ev(11), ev(12));
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    send(13); send(14); send(15);
    vecs++;
    if ({out_valid, out_idx} !== {1'b1, 8'd1}) begin
      errs++;
      $display("FAIL prereset_triplet: got v=%0b idx=%0d, want 1 idx=1", out_valid, out_idx);
    end
    out_ready = 1'b0;
    send(16);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({out_valid, x0, x1, x2, out_idx, out_last, in_ready} !== {1'b0, 96'd0, 8'd0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL async_reset: got v=%0b %h %h %h idx=%0d last=%0b rdy=%0b, want all 0 and rdy=1",
               out_valid, x0, x1, x2, out_idx, out_last, in_ready);
    end
    #1;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(1); send(2); send(3);
    vecs++;
    if ({out_valid, x0, x1, x2, out_idx, out_last} !== {1'b1, ev(1), ev(2), ev(3), 8'd0, 1'b0}) begin
      errs++;
      $display("FAIL postreset_triplet: got v=%0b %h %h %h idx=%0d last=%0b, want 1 %h %h %h idx=0 last=0",
               out_valid, x0, x1, x2, out_idx, out_last, ev(1), ev(2), ev(3));
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef R3_PRESCALE_EN
  task automatic test_prescale;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h7FFF_8000; tick();
    in_data   = 32'hFFFF_0003; tick();
    in_data   = 32'hFFFD_0000; tick();
    in_valid  = 1'b0;
    vecs++;
    if ({x0, x1, x2} !== {32'h4000_C000, 32'h0000_0002, 32'hFFFF_0000}) begin
      errs++;
      $display("FAIL prescale: got %h %h %h, want 4000c000 00000002 ffff0000", x0, x1, x2);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gap();
    test_flush();
    test_async_reset();
`ifdef R3_PRESCALE_EN
    test_prescale();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
